// File: rtl/fmiller_pkg.sv
// Shared constants for the frame-level receive controller around fmiller_decoder.
package fmiller_pkg;

    localparam int          BYTE_W        = 8;
    localparam int          SYNC_W_DEF    = 16;
    localparam logic [15:0] SYNC_WORD_DEF = 16'hD391;
    localparam int          MAX_LEN_DEF   = 64;

    // Controller state encoding, kept as plain constants for legacy tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_HUNT = 3'd1;
    localparam state_t ST_LEN  = 3'd2;
    localparam state_t ST_DATA = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Busy covers the part of a frame after sync where bits are being consumed.
    function automatic logic is_busy(input state_t s);
        return (s == ST_LEN) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/fmiller_byte_buf.sv
// Single-entry valid/ready output register. A byte offered while the register
// is still full and not being drained is dropped and flagged in a sticky ovf.
module fmiller_byte_buf
    import fmiller_pkg::*;
(
    input  logic              clk2x,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              load,
    input  logic [BYTE_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ovf_clr,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    output logic              ovf
);

    logic [BYTE_W-1:0] data_r;
    logic              valid_r;
    logic              last_r;
    logic              ovf_r;
    logic              can_load_s;
    logic              accept_s;

    // Slot is free when empty or being drained this very cycle.
    always_comb begin
        can_load_s = (!valid_r) || out_ready;
        accept_s   = valid_r && out_ready;
    end

    // Output register: a new load wins over a same-cycle drain.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            data_r  <= 8'h00;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            if (load && can_load_s) begin
                data_r  <= load_data;
                last_r  <= load_last;
                valid_r <= 1'b1;
            end else if (accept_s) begin
                valid_r <= 1'b0;
                last_r  <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            if (ovf_clr) begin
                ovf_r <= 1'b0;
            end else if (load && !can_load_s) begin
                ovf_r <= 1'b1;
            end else begin
                ovf_r <= ovf_r;
            end
        end
    end

    assign out_data  = data_r;
    assign out_valid = valid_r;
    assign out_last  = last_r;
    assign ovf       = ovf_r;

endmodule

// File: rtl/fmiller_rx_ctrl.sv
// Frame receive controller: hunts for a sync word in the decoded bit stream,
// reads a length byte, then assembles MSB-first payload bytes for downstream.
module fmiller_rx_ctrl
    import fmiller_pkg::*;
#(
    parameter int                SYNC_W    = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int                MAX_LEN   = MAX_LEN_DEF
) (
    input  logic              clk2x,
    input  logic              rst_n,
    input  logic              en,
    input  logic              bit_stb,
    input  logic              dec_bit,
    output logic              dec_enable,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err,
    output logic              ovf,
    output logic              busy
);

    localparam logic [7:0] MAX_LEN_B = MAX_LEN[7:0];

    state_t            state_r, state_nxt_s;
    logic [SYNC_W-1:0] sync_sh_r, sync_nxt_s;
    logic [7:0]        byte_sh_r, byte_nxt_s;
    logic [2:0]        bit_cnt_r;
    logic [7:0]        byte_cnt_r;
    logic [7:0]        len_r;
    logic              dec_enable_r, busy_r;
    logic              frame_start_r, frame_done_r, frame_err_r;
    logic              start_s, done_s, err_s, load_s, clr_sync_s;
    logic              byte_done_s, last_byte_s, shift_en_s;

    // Next-state and per-cycle event decode; en low overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        done_s      = 1'b0;
        err_s       = 1'b0;
        load_s      = 1'b0;
        clr_sync_s  = 1'b0;
        sync_nxt_s  = {sync_sh_r[SYNC_W-2:0], dec_bit};
        byte_nxt_s  = {byte_sh_r[6:0], dec_bit};
        byte_done_s = bit_stb && (bit_cnt_r == 3'd7);
        last_byte_s = (byte_cnt_r == (len_r - 8'd1));
        shift_en_s  = en && bit_stb && is_busy(state_r);
        if (!en) begin
            state_nxt_s = ST_IDLE;
            clr_sync_s  = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = ST_HUNT;
                ST_HUNT: begin
                    if (bit_stb && (sync_nxt_s == SYNC_WORD)) begin
                        state_nxt_s = ST_LEN;
                        start_s     = 1'b1;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_LEN: begin
                    if (!byte_done_s) begin
                        state_nxt_s = ST_LEN;
                    end else if (byte_nxt_s == 8'd0) begin
                        state_nxt_s = ST_DONE;
                        done_s      = 1'b1;
                    end else if (byte_nxt_s > MAX_LEN_B) begin
                        state_nxt_s = ST_HUNT;
                        err_s       = 1'b1;
                        clr_sync_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (byte_done_s) begin
                        load_s = 1'b1;
                        if (last_byte_s) begin
                            state_nxt_s = ST_DONE;
                            done_s      = 1'b1;
                        end else begin
                            state_nxt_s = ST_DATA;
                        end
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_HUNT;
                    clr_sync_s  = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    clr_sync_s  = 1'b1;
                end
            endcase
        end
    end

    // State, counters, shift registers and registered status pulses.
    always_ff @(posedge clk2x or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            sync_sh_r     <= '0;
            byte_sh_r     <= 8'h00;
            bit_cnt_r     <= 3'd0;
            byte_cnt_r    <= 8'd0;
            len_r         <= 8'd0;
            dec_enable_r  <= 1'b0;
            busy_r        <= 1'b0;
            frame_start_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            dec_enable_r  <= (state_nxt_s != ST_IDLE);
            busy_r        <= is_busy(state_nxt_s);
            frame_start_r <= start_s;
            frame_done_r  <= done_s;
            frame_err_r   <= err_s;
            if (clr_sync_s) begin
                sync_sh_r <= '0;
            end else if (en && bit_stb && (state_r == ST_HUNT)) begin
                sync_sh_r <= sync_nxt_s;
            end else begin
                sync_sh_r <= sync_sh_r;
            end
            if (!en || start_s) begin
                bit_cnt_r <= 3'd0;
            end else if (shift_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            if (shift_en_s) begin
                byte_sh_r <= byte_nxt_s;
            end
            if (start_s) begin
                byte_cnt_r <= 8'd0;
            end else if (load_s) begin
                byte_cnt_r <= byte_cnt_r + 8'd1;
            end
            if (en && (state_r == ST_LEN) && byte_done_s) begin
                len_r <= byte_nxt_s;
            end
        end
    end

    fmiller_byte_buf u_buf (
        .clk2x     (clk2x),
        .rst_n     (rst_n),
        .flush     (!en),
        .load      (load_s),
        .load_data (byte_nxt_s),
        .load_last (last_byte_s),
        .ovf_clr   (start_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .ovf       (ovf)
    );

    assign dec_enable  = dec_enable_r;
    assign busy        = busy_r;
    assign frame_start = frame_start_r;
    assign frame_done  = frame_done_r;
    assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_fmiller_rx_ctrl.sv
// Bench for fmiller_rx_ctrl: directed scenarios plus randomized frames checked
// against a stream-level parser of the bits that were sent.
module tb_fmiller_rx_ctrl;

    localparam logic [15:0] SYNC = 16'hD391;
    localparam int          MAXL = 64;

    logic       clk2x = 1'b0;
    logic       rst_n, en, bit_stb, dec_bit, out_ready;
    logic       dec_enable, out_valid, out_last;
    logic [7:0] out_data;
    logic       frame_start, frame_done, frame_err, ovf, busy;

    fmiller_rx_ctrl dut (
        .clk2x(clk2x), .rst_n(rst_n), .en(en), .bit_stb(bit_stb), .dec_bit(dec_bit),
        .dec_enable(dec_enable), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_start(frame_start),
        .frame_done(frame_done), .frame_err(frame_err), .ovf(ovf), .busy(busy)
    );

    always #5 clk2x = ~clk2x;

    int n_vec = 0;
    int n_bad = 0;

    // Monitor: counts pulses and records accepted bytes as {last, data}.
    int mon_start = 0, mon_done = 0, mon_err = 0;
    int obs_q[$];
    always @(negedge clk2x) begin
        if (rst_n) begin
            if (frame_start) mon_start++;
            if (frame_done)  mon_done++;
            if (frame_err)   mon_err++;
            if (out_valid && out_ready) obs_q.push_back({23'd0, out_last, out_data});
        end
    end

    bit sent_q[$];
    int base_start, base_done, base_err, base_obs;

    task automatic tick();
        @(posedge clk2x);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic begin_scn();
        sent_q.delete();
        base_start = mon_start;
        base_done  = mon_done;
        base_err   = mon_err;
        base_obs   = obs_q.size();
    endtask

    task automatic strobe(input logic b);
        bit_stb = 1'b1;
        dec_bit = b;
        sent_q.push_back(b);
        tick();
        bit_stb = 1'b0;
        dec_bit = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bit(input logic b);
        strobe(b);
        tick();
        tick();
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_sync_checked(input string tag);
        logic [15:0] sw;
        sw = SYNC;
        for (int i = 15; i >= 1; i--) send_bit(sw[i]);
        strobe(sw[0]);
        chk({tag, "_start"}, 32'(frame_start), 1);
        chk({tag, "_busy"},  32'(busy), 1);
        chk({tag, "_ovf"},   32'(ovf), 0);
        tick();
        tick();
    endtask

    task automatic send_frame(input int len, input int pay_n);
        send_bits(32'($urandom), $urandom_range(0, 3));
        send_bits({16'd0, SYNC}, 16);
        send_bits(32'(len), 8);
        for (int b = 0; b < pay_n; b++) send_bits(32'($urandom_range(0, 255)), 8);
        tick();
        tick();
    endtask

    // Reference: parse the sent bit stream by the framing rules, compare events.
    task automatic model_check(input string tag);
        int i, len, byt, es, ed, ee;
        logic [15:0] win;
        int exp_q[$];
        i = 0; es = 0; ed = 0; ee = 0; win = 16'd0;
        while (i < sent_q.size()) begin
            win = {win[14:0], sent_q[i]};
            i++;
            if (win == SYNC) begin
                es++;
                if (i + 8 > sent_q.size()) break;
                len = 0;
                for (int k = 0; k < 8; k++) len = (len << 1) | int'(sent_q[i + k]);
                i += 8;
                if (len == 0) begin
                    ed++;
                end else if (len > MAXL) begin
                    ee++;
                end else begin
                    if (i + 8 * len > sent_q.size()) break;
                    for (int b = 0; b < len; b++) begin
                        byt = 0;
                        for (int k = 0; k < 8; k++) byt = (byt << 1) | int'(sent_q[i + k]);
                        i += 8;
                        exp_q.push_back(((b == len - 1) ? 256 : 0) + byt);
                    end
                    ed++;
                end
                win = 16'd0;
            end
        end
        chk({tag, "_starts"}, mon_start - base_start, es);
        chk({tag, "_dones"},  mon_done - base_done, ed);
        chk({tag, "_errs"},   mon_err - base_err, ee);
        chk({tag, "_nbytes"}, obs_q.size() - base_obs, exp_q.size());
        for (int j = 0; j < exp_q.size() && (base_obs + j) < obs_q.size(); j++)
            chk({tag, "_byte"}, obs_q[base_obs + j], exp_q[j]);
    endtask

    logic [7:0] b1, b2, b3;
    int rl;

    initial begin
        rst_n = 1'b0; en = 1'b0; bit_stb = 1'b0; dec_bit = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst_dec_en", 32'(dec_enable), 0);
        chk("rst_valid",  32'(out_valid), 0);
        chk("rst_data",   32'(out_data), 0);
        chk("rst_last",   32'(out_last), 0);
        chk("rst_pulses", 32'({frame_start, frame_done, frame_err}), 0);
        chk("rst_ovf_busy", 32'({ovf, busy}), 0);
        tick(); rst_n = 1'b1; tick();
        chk("idle_dec_en", 32'(dec_enable), 0);
        en = 1'b1; tick();
        chk("hunt_dec_en", 32'(dec_enable), 1);
        chk("hunt_busy",   32'(busy), 0);

        // Basic frame D391 / 03 / A5 3C FF
        begin_scn();
        send_bits(32'($urandom), $urandom_range(0, 3));
        send_sync_checked("s1");
        send_bits(32'h03, 8);
        send_bits(32'hA5, 8);
        send_bits(32'h3C, 8);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        strobe(1'b1);
        chk("s1_done",  32'(frame_done), 1);
        chk("s1_valid", 32'(out_valid), 1);
        chk("s1_data",  32'(out_data), 32'hFF);
        chk("s1_last",  32'(out_last), 1);
        chk("s1_busy",  32'(busy), 0);
        tick();
        chk("s1_done_once", 32'(frame_done), 0);
        tick(); tick();
        model_check("s1");
        chk("s1_ovf", 32'(ovf), 0);

        // One-bit-off sync followed by a good frame
        begin_scn();
        send_bits(32'hD390, 16);
        rl = $urandom_range(1, 6);
        send_frame(rl, rl);
        model_check("s2");

        // Zero length, then illegal length 0x41
        begin_scn();
        send_frame(0, 0);
        model_check("s3a");
        begin_scn();
        send_sync_checked("s3b");
        send_bits(32'h20, 7);
        strobe(1'b1);
        chk("s3b_err",    32'(frame_err), 1);
        chk("s3b_busy",   32'(busy), 0);
        chk("s3b_dec_en", 32'(dec_enable), 1);
        tick();
        chk("s3b_err_once", 32'(frame_err), 0);
        tick(); tick();
        model_check("s3b");

        // Back-pressure for a whole 3-byte frame
        out_ready = 1'b0;
        b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
        begin_scn();
        send_sync_checked("s4");
        send_bits(32'h03, 8);
        send_bits(32'(b1), 8);
        chk("s4_b1_valid", 32'(out_valid), 1);
        chk("s4_b1_data",  32'(out_data), 32'(b1));
        chk("s4_b1_ovf",   32'(ovf), 0);
        send_bits(32'(b2), 8);
        chk("s4_b2_ovf",   32'(ovf), 1);
        chk("s4_b2_data",  32'(out_data), 32'(b1));
        send_bits(32'(b3), 8);
        chk("s4_b3_valid", 32'(out_valid), 1);
        chk("s4_b3_data",  32'(out_data), 32'(b1));
        chk("s4_b3_last",  32'(out_last), 0);
        chk("s4_b3_ovf",   32'(ovf), 1);
        chk("s4_done",     mon_done - base_done, 1);
        out_ready = 1'b1;
        tick();
        chk("s4_drained", 32'(out_valid), 0);
        chk("s4_nacc", obs_q.size() - base_obs, 1);
        if (obs_q.size() > base_obs) chk("s4_acc", obs_q[base_obs], 32'(b1));
        send_sync_checked("s4_clr");
        send_bits(32'h00, 8);
        tick(); tick();

        // Enable dropped after the second payload byte
        begin_scn();
        send_sync_checked("s5");
        send_bits(32'h04, 8);
        send_bits(32'($urandom), 8);
        send_bits(32'($urandom), 8);
        en = 1'b0;
        tick();
        chk("s5_dec_en", 32'(dec_enable), 0);
        chk("s5_valid",  32'(out_valid), 0);
        chk("s5_busy",   32'(busy), 0);
        chk("s5_last",   32'(out_last), 0);
        tick(); tick();
        chk("s5_no_done", mon_done - base_done, 0);
        en = 1'b1; tick(); tick();
        begin_scn();
        rl = $urandom_range(1, 8);
        send_frame(rl, rl);
        model_check("s5r");

        // Asynchronous reset in the middle of DATA
        begin_scn();
        send_sync_checked("s6");
        send_bits(32'h05, 8);
        send_bits(32'($urandom), 8);
        send_bits(32'($urandom), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("s6_dec_en", 32'(dec_enable), 0);
        chk("s6_valid",  32'(out_valid), 0);
        chk("s6_data",   32'(out_data), 0);
        chk("s6_last",   32'(out_last), 0);
        chk("s6_pulses", 32'({frame_start, frame_done, frame_err}), 0);
        chk("s6_ovf_busy", 32'({ovf, busy}), 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("s6_idle", 32'({dec_enable, busy}), 0);
        tick();
        chk("s6_hunt", 32'(dec_enable), 1);
        tick();

        // Randomized frames, including boundary and illegal lengths
        for (int f = 0; f < 8; f++) begin
            case ($urandom_range(0, 9))
                0:       rl = 0;
                1:       rl = MAXL;
                2:       rl = $urandom_range(MAXL + 1, 255);
                default: rl = $urandom_range(1, 12);
            endcase
            begin_scn();
            send_frame(rl, (rl <= MAXL) ? rl : 0);
            model_check("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
